// File: rtl/shift_pkg.sv
// Shared types and defaults for the multi-cycle shifter.
package shift_pkg;

    // Shift operation encoding as presented on the op input
    typedef enum logic [1:0] {
        SLL = 2'b00,
        SRL = 2'b01,
        SRA = 2'b10,
        RSV = 2'b11
    } shift_op_e;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    // Bits moved per cycle while enough shift distance remains
    localparam int BIG_STEP_DEFAULT = 4;

endpackage

// File: rtl/shift_step.sv
// One combinational shift step: either BIG_STEP bits or a single bit.
// SRA fills from msb_fill so the sign of the original operand is kept
// regardless of how many steps have already been applied.
module shift_step
    import shift_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int BIG_STEP = BIG_STEP_DEFAULT
) (
    input  logic [XLEN-1:0] value,
    input  logic [1:0]      op,
    input  logic            msb_fill,
    input  logic            big,
    output logic [XLEN-1:0] stepped
);

    logic [XLEN-1:0] w_ones;
    logic [XLEN-1:0] w_fill;
    logic [XLEN-1:0] w_mask_big;
    logic [XLEN-1:0] w_mask_one;

    assign w_ones     = {XLEN{1'b1}};
    assign w_fill     = {XLEN{msb_fill}};
    assign w_mask_big = ~(w_ones >> BIG_STEP);
    assign w_mask_one = ~(w_ones >> 1'b1);

    // Select the stepped value for the requested operation and step size
    always_comb begin
        stepped = value;
        case (op)
            SLL: begin
                if (big) stepped = value << BIG_STEP;
                else     stepped = value << 1'b1;
            end
            SRL: begin
                if (big) stepped = value >> BIG_STEP;
                else     stepped = value >> 1'b1;
            end
            SRA: begin
                if (big) stepped = (value >> BIG_STEP) | (w_fill & w_mask_big);
                else     stepped = (value >> 1'b1)     | (w_fill & w_mask_one);
            end
            default: stepped = value;
        endcase
    end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shifter: accepts one request at a time, walks the shift
// distance down in BIG_STEP or 1-bit steps, and holds the result until the
// consumer takes it. A new request may be accepted in the same cycle the
// previous result is consumed.
module shift_seq
    import shift_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int BIG_STEP = BIG_STEP_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [4:0]      shamt,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rd,
    output logic            busy
);

    localparam logic [4:0] BIG_AMT = 5'(BIG_STEP);

    state_e          r_state;
    logic [XLEN-1:0] r_work;
    logic [4:0]      r_rem;
    logic [1:0]      r_op;
    logic            r_msb;
    logic            r_out_valid;
    logic            r_busy;

    logic            w_in_ready;
    logic            w_accept;
    logic            w_big;
    logic [4:0]      w_step_amt;
    logic [4:0]      w_rem_next;
    logic [XLEN-1:0] w_stepped;

    // Request window: open in IDLE, or in DONE while the result is being consumed
    always_comb begin
        w_in_ready = 1'b0;
        if (rst || flush) begin
            w_in_ready = 1'b0;
        end else if (r_state == IDLE) begin
            w_in_ready = 1'b1;
        end else if (r_state == DONE) begin
            w_in_ready = out_ready;
        end else begin
            w_in_ready = 1'b0;
        end
    end

    assign w_accept = in_valid & w_in_ready;

    // Choose this cycle's step size and the remaining distance after it
    always_comb begin
        w_big      = (r_rem >= BIG_AMT);
        w_step_amt = 5'd1;
        if (w_big) begin
            w_step_amt = BIG_AMT;
        end else begin
            w_step_amt = 5'd1;
        end
        w_rem_next = r_rem - w_step_amt;
    end

    shift_step #(
        .XLEN     (XLEN),
        .BIG_STEP (BIG_STEP)
    ) u_step (
        .value    (r_work),
        .op       (r_op),
        .msb_fill (r_msb),
        .big      (w_big),
        .stepped  (w_stepped)
    );

    // Sequencer: reset, flush, request load, stepping and result handoff
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_work      <= '0;
            r_rem       <= 5'd0;
            r_op        <= 2'b00;
            r_msb       <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else if (flush) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else if (w_accept) begin
            // Only reachable from IDLE or from DONE while the result is taken
            r_work <= rs1;
            r_op   <= op;
            r_msb  <= rs1[XLEN-1];
            r_rem  <= shamt;
            r_busy <= 1'b1;
            if (shamt == 5'd0) begin
                r_state     <= DONE;
                r_out_valid <= 1'b1;
            end else begin
                r_state     <= SHIFT;
                r_out_valid <= 1'b0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
                SHIFT: begin
                    r_work <= w_stepped;
                    r_rem  <= w_rem_next;
                    if (w_rem_next == 5'd0) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_state     <= SHIFT;
                        r_out_valid <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end else begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign rd        = r_work;

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: directed scenarios plus randomized
// requests compared against a plain-arithmetic reference model.
module tb_shift_seq;

    localparam int XLEN = 32;
    localparam int BS   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        op;
    logic [XLEN-1:0]   rs1;
    logic [4:0]        shamt;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   rd;
    logic              busy;

    int errors = 0;
    int checks = 0;

    shift_seq #(.XLEN(XLEN), .BIG_STEP(BS)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs1       (rs1),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rd        (rd),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference result straight from the shift definitions
    function automatic logic [31:0] model_rd(input logic [1:0] o, input logic [31:0] a, input int s);
        logic signed [31:0] sa;
        sa = a;
        case (o)
            2'd0:    return a << s;
            2'd1:    return a >> s;
            2'd2:    return sa >>> s;
            default: return a;
        endcase
    endfunction

    // Cycles from acceptance edge to first sample of out_valid
    function automatic int model_lat(input int s);
        return s / BS + s % BS + 1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one request with out_ready high, check latency, result and return to idle
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [4:0] s,
                         output logic [31:0] got);
        int k;
        logic [31:0] exp_rd;
        int exp_lat;
        exp_rd  = model_rd(o, a, int'(s));
        exp_lat = model_lat(int'(s));
        op = o; rs1 = a; shamt = s; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL op_in_ready: got %b want 1", in_ready);
        end
        tick;
        in_valid = 1'b0; op = 2'($urandom); rs1 = $urandom; shamt = 5'($urandom);
        k = 1;
        while (out_valid !== 1'b1 && k < 40) begin
            checks++;
            if (busy !== 1'b1) begin
                errors++; $display("FAIL op_busy: cycle %0d got %b want 1", k, busy);
            end
            tick;
            k++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL op_timeout: out_valid %b want 1 within 40 cycles", out_valid);
        end
        checks++;
        if (k != exp_lat) begin
            errors++; $display("FAIL op_latency: op=%0d shamt=%0d got %0d want %0d", o, s, k, exp_lat);
        end
        checks++;
        if (rd !== exp_rd) begin
            errors++; $display("FAIL op_rd: op=%0d rs1=%h shamt=%0d got %h want %h", o, a, s, rd, exp_rd);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL op_busy_done: got %b want 1", busy);
        end
        got = rd;
        tick;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL op_idle: out_valid=%b busy=%b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 2'd0; rs1 = '0; shamt = 5'd0;
        tick; tick;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: out_valid=%b busy=%b want 0 0", out_valid, busy);
        end
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL reset_rd: got %h want 0", rd);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_directed;
        logic [31:0] got;
        do_op(2'd0, 32'h0000_0001, 5'd31, got);
        checks++;
        if (got !== 32'h8000_0000) begin
            errors++; $display("FAIL sll31: got %h want 80000000", got);
        end
        do_op(2'd2, 32'h8000_00F0, 5'd5, got);
        checks++;
        if (got !== 32'hFC00_0007) begin
            errors++; $display("FAIL sra5: got %h want fc000007", got);
        end
        do_op(2'd1, 32'h8000_00F0, 5'd5, got);
        checks++;
        if (got !== 32'h0400_0007) begin
            errors++; $display("FAIL srl5: got %h want 04000007", got);
        end
        do_op(2'd3, 32'hDEAD_BEEF, 5'd7, got);
        checks++;
        if (got !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL rsv: got %h want deadbeef", got);
        end
    endtask

    task automatic test_random;
        logic [31:0] got;
        logic [4:0]  s;
        for (int i = 0; i < 24; i++) begin
            case (i)
                0:       s = 5'd0;
                1:       s = 5'd31;
                2:       s = 5'd3;
                3:       s = 5'd4;
                default: s = 5'($urandom_range(0, 31));
            endcase
            do_op(2'($urandom_range(0, 3)), $urandom, s, got);
        end
    endtask

    task automatic test_hold;
        op = 2'd0; rs1 = 32'h1234_5678; shamt = 5'd0; in_valid = 1'b1; out_ready = 1'b0;
        #1;
        tick;
        in_valid = 1'b0; rs1 = $urandom;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || rd !== 32'h1234_5678) begin
                errors++; $display("FAIL hold_rd: cycle %0d valid=%b rd=%h want 1 12345678", i, out_valid, rd);
            end
            checks++;
            if (in_ready !== 1'b0) begin
                errors++; $display("FAIL hold_in_ready: cycle %0d got %b want 0", i, in_ready);
            end
            if (i < 3) tick;
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL hold_release_ready: got %b want 1", in_ready);
        end
        tick;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL hold_idle: out_valid=%b busy=%b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_back_to_back;
        int k;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  ob;
        a = $urandom;
        op = 2'd1; rs1 = a; shamt = 5'd1; in_valid = 1'b1; out_ready = 1'b0;
        #1;
        tick;
        in_valid = 1'b0;
        k = 1;
        while (out_valid !== 1'b1 && k < 40) begin tick; k++; end
        checks++;
        if (out_valid !== 1'b1 || rd !== model_rd(2'd1, a, 1)) begin
            errors++; $display("FAIL b2b_first: valid=%b rd=%h want 1 %h", out_valid, rd, model_rd(2'd1, a, 1));
        end
        op = 2'd0; rs1 = 32'h1; shamt = 5'd4; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_ready: got %b want 1", in_ready);
        end
        tick;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL b2b_shift: out_valid=%b busy=%b want 0 1", out_valid, busy);
        end
        tick;
        checks++;
        if (out_valid !== 1'b1 || rd !== 32'h10) begin
            errors++; $display("FAIL b2b_result: valid=%b rd=%h want 1 00000010", out_valid, rd);
        end
        b = $urandom; ob = 2'($urandom);
        op = ob; rs1 = b; shamt = 5'd0; in_valid = 1'b1;
        #1;
        tick;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || rd !== model_rd(ob, b, 0)) begin
            errors++; $display("FAIL b2b_zero: valid=%b rd=%h want 1 %h", out_valid, rd, model_rd(ob, b, 0));
        end
        tick;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_idle: out_valid=%b busy=%b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_flush;
        logic [31:0] got;
        op = 2'd0; rs1 = $urandom; shamt = 5'd31; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        tick;
        in_valid = 1'b0;
        tick; tick;
        flush = 1'b1; in_valid = 1'b1; op = 2'd1; rs1 = 32'hFFFF_0000; shamt = 5'd0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL flush_in_ready: got %b want 0", in_ready);
        end
        tick;
        flush = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL flush_shift: cycle %0d out_valid=%b busy=%b want 0 0", i, out_valid, busy);
            end
            tick;
        end
        op = 2'd0; rs1 = $urandom; shamt = 5'd0; in_valid = 1'b1; out_ready = 1'b0;
        #1;
        tick;
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        tick;
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL flush_done: out_valid=%b busy=%b want 0 0", out_valid, busy);
        end
        do_op(2'd2, 32'hF000_000F, 5'd9, got);
    endtask

    task automatic test_reset_mid;
        logic [31:0] got;
        op = 2'd0; rs1 = $urandom; shamt = 5'd0; in_valid = 1'b1; out_ready = 1'b0;
        #1;
        tick;
        in_valid = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_done: out_valid=%b busy=%b in_ready=%b want 0 0 1", out_valid, busy, in_ready);
        end
        op = 2'd1; rs1 = $urandom; shamt = 5'd31; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        tick;
        in_valid = 1'b0;
        tick;
        rst = 1'b1; flush = 1'b1; in_valid = 1'b1;
        tick;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || rd !== 32'h0) begin
            errors++; $display("FAIL rst_shift: out_valid=%b busy=%b rd=%h want 0 0 0", out_valid, busy, rd);
        end
        do_op(2'd0, 32'h0000_00A5, 5'd13, got);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_directed;
        test_hold;
        test_back_to_back;
        test_flush;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_seq.md
SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the operand and result width.
REQ-002 SHALL have parameter BIG_STEP, default 4, meaning the bits shifted per cycle while the remaining count is at least BIG_STEP.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 flush  input  1  abort the current operation; the result is discarded.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  request accepted when high together with in_valid.
REQ-008 op  input  2  shift type: 00 SLL, 01 SRL, 10 SRA, 11 reserved.
REQ-009 rs1  input  XLEN  operand.
REQ-010 shamt  input  5  shift amount, 0..31.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 rd  output  XLEN  result.
REQ-014 busy  output  1  high in SHIFT or DONE.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-016 in_ready SHALL be high in IDLE, and in DONE when out_ready is high.
REQ-017 in_ready SHALL be low in SHIFT and whenever flush is high.
REQ-018 On acceptance, SHALL register op, rs1 and shamt into the working register and the remaining counter.
REQ-019 On acceptance, SHALL go to DONE if shamt==0, otherwise to SHIFT.
REQ-020 Each SHIFT cycle SHALL perform one step: BIG_STEP bits if remaining>=BIG_STEP, else 1 bit; remaining decrements by the same amount.
REQ-021 SHALL go from SHIFT to DONE on the edge where remaining reaches 0.
REQ-022 Step count SHALL be floor(shamt/4)+(shamt mod 4); out_valid rises exactly steps+1 cycles after the acceptance edge (shamt=0 gives 1 cycle).
REQ-023 SLL SHALL zero-fill the LSBs, SRL SHALL zero-fill the MSBs, and SRA SHALL fill the MSBs with the original rs1[XLEN-1].
REQ-024 op=11 SHALL produce rd=rs1 unchanged with the same latency as SLL.
REQ-025 In DONE, out_valid SHALL be 1 and rd SHALL hold stable until out_ready is high.
REQ-026 On out_ready with no new acceptance, SHALL go from DONE to IDLE.
REQ-027 On out_ready with a simultaneous acceptance, SHALL load the new request and go to SHIFT or DONE per REQ-019, with no idle bubble.
REQ-028 Outside DONE, out_valid SHALL be 0; rd is don't-care outside DONE.
REQ-029 flush SHALL force IDLE on the next edge from any state.
REQ-030 flush SHALL win over a simultaneous acceptance and a simultaneous out_ready; no result is emitted.
REQ-031 busy SHALL equal (state != IDLE).

Reset
REQ-032 While rst is high at an edge, SHALL set state to IDLE, working register to 0, remaining to 0, out_valid to 0, busy to 0, and in_ready to 1 from the following cycle.
REQ-033 rst SHALL override flush and all handshakes, including reset in the middle of SHIFT or DONE.

Structure
REQ-034 Package shift_pkg SHALL hold the op enum (SLL, SRL, SRA, RSV), the state enum, and the BIG_STEP default.
REQ-035 SHALL instantiate one combinational sub-module, shift_step, with inputs value, op, msb_fill and big (1 = BIG_STEP, 0 = 1 bit), and output the stepped value.
REQ-036 The FSM, counter and handshake SHALL reside in shift_seq.

Verification
REQ-037 SLL rs1=0x0000_0001, shamt=31, out_ready=1 -> out_valid 11 cycles after acceptance, rd=0x8000_0000, busy high throughout.
REQ-038 SRA rs1=0x8000_00F0, shamt=5 -> out_valid 3 cycles after acceptance, rd=0xFC00_0007; SRL of the same operand -> rd=0x0400_0007.
REQ-039 shamt=0, rs1=0x1234_5678, out_ready held low for 4 cycles -> out_valid 1 cycle after acceptance, rd stable at 0x1234_5678 for all 4 cycles, in_ready low until out_ready rises.
REQ-040 Back-to-back: DONE with out_ready=1 and in_valid=1 (SLL 0x1, shamt=4) -> the next cycle is SHIFT, and the new result 0x10 appears 2 cycles after the handoff.
REQ-041 flush asserted in the 3rd SHIFT cycle together with in_valid -> IDLE next cycle, no out_valid pulse, the request is not accepted, and a following request completes normally.
REQ-042 rst asserted in DONE with out_ready=0 -> next cycle out_valid=0, busy=0, in_ready=1.
